comparador_serial_di: RTL and testbench

COMPARADOR_SERIAL_DI -- requirements
Module: comparador_serial_di

---
 rtl/comparador_serial_di.sv | 160 ++++++++++++++++
 tb/tb_comparador_serial_di.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/comparador_serial_di.sv
// comparador_serial_di: bit-serial unsigned magnitude comparator.
// A single one-bit comparison cell is time-multiplexed over K cycles,
// walking from the LSB to the MSB. Each higher bit that differs
// overwrites the partial verdict, so the verdict left after the MSB is
// the full unsigned comparison.
module comparador_serial_di #(
    parameter int unsigned K = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inicio,
    input  logic [K-1:0] A,
    input  logic [K-1:0] B,
    output logic         ocupado,
    output logic         listo,
    output logic         MAYOR,
    output logic         MENOR,
    output logic         IGUAL
);

    // Bit index width; the index only ever counts 0..K-1.
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] ULTIMO = IW'(K - 1);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        COMPARA = 2'd1,
        FIN     = 2'd2
    } estado_t;

    // Running verdict carried from bit to bit.
    typedef enum logic [1:0] {
        REL_IGUAL = 2'd0,
        REL_MAYOR = 2'd1,
        REL_MENOR = 2'd2
    } rel_t;

    estado_t       estado;
    estado_t       estado_nxt;

    logic [K-1:0]  a_reg;
    logic [K-1:0]  b_reg;
    logic [K-1:0]  a_nxt;
    logic [K-1:0]  b_nxt;

    logic [IW-1:0] indice;
    logic [IW-1:0] indice_nxt;

    rel_t          parcial;
    rel_t          parcial_nxt;
    rel_t          rel_bit;

    logic          bit_a;
    logic          bit_b;

    logic          ocupado_nxt;
    logic          listo_nxt;
    logic          mayor_nxt;
    logic          menor_nxt;
    logic          igual_nxt;

    // Shared comparison cell: selects the current bit pair and updates the verdict.
    always_comb begin
        bit_a   = a_reg[indice];
        bit_b   = b_reg[indice];
        rel_bit = parcial;
        if (bit_a != bit_b) begin
            rel_bit = bit_a ? REL_MAYOR : REL_MENOR;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= ESPERA;
        end else begin
            estado <= estado_nxt;
        end
    end

    // Next-state and next-value logic for datapath and registered outputs.
    always_comb begin
        estado_nxt  = estado;
        a_nxt       = a_reg;
        b_nxt       = b_reg;
        indice_nxt  = indice;
        parcial_nxt = parcial;
        ocupado_nxt = ocupado;
        listo_nxt   = 1'b0;
        mayor_nxt   = MAYOR;
        menor_nxt   = MENOR;
        igual_nxt   = IGUAL;

        case (estado)
            ESPERA: begin
                ocupado_nxt = 1'b0;
                if (inicio) begin
                    a_nxt       = A;
                    b_nxt       = B;
                    indice_nxt  = '0;
                    parcial_nxt = REL_IGUAL;
                    ocupado_nxt = 1'b1;
                    estado_nxt  = COMPARA;
                end
            end

            COMPARA: begin
                parcial_nxt = rel_bit;
                if (indice == ULTIMO) begin
                    // MSB done: publish the verdict and park the index at 0.
                    indice_nxt = '0;
                    listo_nxt  = 1'b1;
                    mayor_nxt  = (rel_bit == REL_MAYOR);
                    menor_nxt  = (rel_bit == REL_MENOR);
                    igual_nxt  = (rel_bit == REL_IGUAL);
                    estado_nxt = FIN;
                end else begin
                    indice_nxt = indice + IW'(1);
                end
            end

            FIN: begin
                ocupado_nxt = 1'b0;
                estado_nxt  = ESPERA;
            end

            default: begin
                ocupado_nxt = 1'b0;
                indice_nxt  = '0;
                estado_nxt  = ESPERA;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any comparison in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            indice  <= '0;
            parcial <= REL_IGUAL;
            ocupado <= 1'b0;
            listo   <= 1'b0;
            MAYOR   <= 1'b0;
            MENOR   <= 1'b0;
            IGUAL   <= 1'b0;
        end else begin
            a_reg   <= a_nxt;
            b_reg   <= b_nxt;
            indice  <= indice_nxt;
            parcial <= parcial_nxt;
            ocupado <= ocupado_nxt;
            listo   <= listo_nxt;
            MAYOR   <= mayor_nxt;
            MENOR   <= menor_nxt;
            IGUAL   <= igual_nxt;
        end
    end

endmodule

// File: tb/tb_comparador_serial_di.sv
// Directed bench for comparador_serial_di with K=8.
module tb_comparador_serial_di;

    localparam int unsigned K = 8;

    logic         clk;
    logic         reset;
    logic         inicio;
    logic [K-1:0] A;
    logic [K-1:0] B;
    logic         ocupado;
    logic         listo;
    logic         MAYOR;
    logic         MENOR;
    logic         IGUAL;

    int checks;
    int errors;
    int pulsos;

    comparador_serial_di #(.K(K)) dut (
        .clk     (clk),
        .reset   (reset),
        .inicio  (inicio),
        .A       (A),
        .B       (B),
        .ocupado (ocupado),
        .listo   (listo),
        .MAYOR   (MAYOR),
        .MENOR   (MENOR),
        .IGUAL   (IGUAL)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic ma, input logic me, input logic ig);
        chk({tag, "_mayor"}, MAYOR, ma);
        chk({tag, "_menor"}, MENOR, me);
        chk({tag, "_igual"}, IGUAL, ig);
    endtask

    // One full comparison: request at edge 0, result at edge K, idle after K+1.
    task automatic run_cmp(input logic [K-1:0] a, input logic [K-1:0] b,
                           input logic ma, input logic me, input logic ig,
                           input string tag);
        A      = a;
        B      = b;
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        chk({tag, "_ocupado_e0"}, ocupado, 1'b1);
        chk({tag, "_listo_e0"}, listo, 1'b0);
        for (int e = 1; e < int'(K); e++) begin
            tick();
            chk({tag, "_listo_early"}, listo, 1'b0);
        end
        tick();
        chk({tag, "_listo_eK"}, listo, 1'b1);
        chk({tag, "_ocupado_eK"}, ocupado, 1'b1);
        chk_res({tag, "_eK"}, ma, me, ig);
        tick();
        chk({tag, "_listo_eK1"}, listo, 1'b0);
        chk({tag, "_ocupado_eK1"}, ocupado, 1'b0);
        chk_res({tag, "_hold"}, ma, me, ig);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulsos = 0;
        reset  = 1'b0;
        inicio = 1'b0;
        A      = '0;
        B      = '0;

        // Reset state, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_listo", listo, 1'b0);
        chk_res("rst", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_clk_listo", listo, 1'b0);
        chk_res("rst_clk", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Equal operands.
        run_cmp(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, "igual_5a");

        // inicio held high: one listo every K+2 edges, mid-run operand changes ignored.
        A      = 8'h10;
        B      = 8'h20;
        inicio = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (listo) pulsos++;
            chk("cont_listo", listo, (e % 10) == 8);
            chk("cont_ocupado", ocupado, (e % 10) != 9);
            if (e == 0) begin
                A = 8'hFF;
                B = 8'h00;
            end
            if (e == 8)  chk_res("cont_r0", 1'b0, 1'b1, 1'b0);
            if (e == 10) begin
                A = 8'h33;
                B = 8'h33;
            end
            if (e == 18) chk_res("cont_r1", 1'b1, 1'b0, 1'b0);
            if (e == 28) chk_res("cont_r2", 1'b0, 1'b0, 1'b1);
        end
        inicio = 1'b0;
        chk_n("cont_pulsos", pulsos, 3);
        tick();
        chk("cont_idle", ocupado, 1'b0);

        // Reset between edges 3 and 4 of a running comparison.
        A      = 8'hC3;
        B      = 8'h3C;
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_ocupado", ocupado, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("abort_ocupado", ocupado, 1'b0);
        chk("abort_listo", listo, 1'b0);
        chk_res("abort", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        pulsos = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (listo) pulsos++;
        end
        chk_n("abort_sin_listo", pulsos, 0);
        chk("abort_post_ocupado", ocupado, 1'b0);
        chk_res("abort_post", 1'b0, 1'b0, 1'b0);

        // Fresh comparisons after reset: MSB dominance and small values.
        run_cmp(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, "msb_80_7f");
        run_cmp(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, "menor_01_02");

        // Back-to-back: second request in the ESPERA cycle right after FIN.
        run_cmp(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, "b2b_ff_00");
        run_cmp(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, "b2b_00_ff");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
